// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to lo_o and remainder to hi_o. done is a one-cycle write strobe.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder, always < divisor
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Next-state, datapath iteration and result write-back.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // One restoring step. The remainder is widened to WIDTH+1 bits. Because rem < divisor,
        // the trial difference is negative exactly when its top bit is set, so that bit is the borrow.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, dvs_q};
        take      = ~rem_trial[WIDTH];
        rem_next  = take ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], take};

        a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
        b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        // Divide by zero: no iteration, fixed architectural result.
                        lo_d    = '1;
                        hi_d    = a;
                        state_d = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_abs;
                        dvs_d     = b_abs;
                        neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = signed_div & a[WIDTH-1];
                        counter_d = '0;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d     = rem_next;
                quo_d     = quo_next;
                counter_d = counter_q + 1'b1;
                if (counter_q == CW'(WIDTH - 1)) begin
                    lo_d    = neg_quo_q ? -quo_next : quo_next;
                    hi_d    = neg_rem_q ? -rem_next : rem_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush/exception: drop everything in flight and keep the previous results.
        if (cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make all flops update from the same pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
